// File: rtl/text_writer_if.sv
// Producer/renderer side of the text buffer: byte handshake, read port and cursor.
interface text_writer_if;
    logic [7:0] charIn_i;
    logic       charValid_i;
    logic       charReady_o;
    logic [5:0] charAddress_i;
    logic [7:0] charOutput_o;
    logic [5:0] cursor_o;

    modport master (
        output charIn_i, charValid_i, charAddress_i,
        input  charReady_o, charOutput_o, cursor_o
    );

    modport slave (
        input  charIn_i, charValid_i, charAddress_i,
        output charReady_o, charOutput_o, cursor_o
    );
endinterface

// File: rtl/text_writer.sv
// 4x16 character buffer fed by a byte stream with LF/CR/BS/FF control handling.
module text_writer #(
    parameter logic [7:0] CLEAR_CHAR = 8'd32
) (
    input logic           clk_i,
    input logic           reset_i,
    text_writer_if.slave  bus
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state, state_next;
    logic [5:0] cursor, cursor_next;
    logic [5:0] clr_cnt, clr_cnt_next;
    logic       we;
    logic [5:0] waddr;
    logic [7:0] wdata;

    // Power-up contents match the cleared screen.
    logic [7:0] mem [64] = '{default: CLEAR_CHAR};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= CLEAR;
            cursor  <= '0;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            cursor  <= cursor_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cursor_next  = cursor;
        clr_cnt_next = clr_cnt;
        we           = 1'b0;
        waddr        = cursor;
        wdata        = bus.charIn_i;

        case (state)
            IDLE: begin
                if (bus.charValid_i) begin
                    if (bus.charIn_i >= 8'h20 && bus.charIn_i <= 8'h7E) begin
                        we          = 1'b1;
                        cursor_next = cursor + 6'd1;
                    end else begin
                        case (bus.charIn_i)
                            8'h0A: cursor_next = {cursor[5:4] + 2'd1, 4'd0};
                            8'h0D: cursor_next = {cursor[5:4], 4'd0};
                            8'h08: begin
                                if (cursor != 6'd0) begin
                                    cursor_next = cursor - 6'd1;
                                    we          = 1'b1;
                                    waddr       = cursor - 6'd1;
                                    wdata       = CLEAR_CHAR;
                                end
                            end
                            8'h0C: begin
                                cursor_next  = '0;
                                clr_cnt_next = '0;
                                state_next   = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                we           = 1'b1;
                waddr        = clr_cnt;
                wdata        = CLEAR_CHAR;
                clr_cnt_next = clr_cnt + 6'd1;
                cursor_next  = '0;
                if (clr_cnt == 6'd63) begin
                    state_next = IDLE;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // Reset suppresses any write decoded on the same edge.
    always_ff @(posedge clk_i) begin
        if (we && !reset_i) begin
            mem[waddr] <= wdata;
        end
    end

    assign bus.charReady_o  = (state == IDLE);
    assign bus.charOutput_o = mem[bus.charAddress_i];
    assign bus.cursor_o     = cursor;

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: expected cells queued as bytes are sent, drained via the read port.
module tb_text_writer;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    text_writer_if tw();

    text_writer #(.CLEAR_CHAR(8'd32)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (tw)
    );

    typedef struct {
        logic [5:0] addr;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_mem [64];
    logic [5:0] m_cur;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_cur = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h20;
    endtask

    task automatic model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_mem[m_cur] = b;
            m_cur = m_cur + 6'd1;
        end else begin
            case (b)
                8'h0A: m_cur = {m_cur[5:4] + 2'd1, 4'd0};
                8'h0D: m_cur[3:0] = 4'd0;
                8'h08: if (m_cur != 6'd0) begin
                    m_cur = m_cur - 6'd1;
                    m_mem[m_cur] = 8'h20;
                end
                8'h0C: model_clear();
                default: ;
            endcase
        end
    endtask

    task automatic push_exp(input logic [5:0] addr, input logic [7:0] val, input string tag);
        exp_t e;
        e.addr = addr;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic push_model(input string tag);
        for (int i = 0; i < 64; i++)
            push_exp(6'(i), m_mem[i], $sformatf("%s[%0d]", tag, i));
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tw.charAddress_i = e.addr;
            #1;
            check(e.tag, 32'(tw.charOutput_o), 32'(e.val));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        check($sformatf("ready_before_%02h", b), 32'(tw.charReady_o), 32'd1);
        tw.charIn_i    = b;
        tw.charValid_i = 1'b1;
        @(posedge clk);
        #1;
        tw.charValid_i = 1'b0;
        model_apply(b);
    endtask

    // Counts edges until ready rises; optionally offers bytes the whole time.
    task automatic wait_clear(input bit offer, input string tag);
        int cnt = 0;
        while (!tw.charReady_o && cnt < 200) begin
            if (offer) begin
                tw.charValid_i = 1'b1;
                tw.charIn_i    = (cnt % 2 == 0) ? 8'h41 : 8'h07;
            end
            @(posedge clk);
            #1;
            cnt++;
        end
        tw.charValid_i = 1'b0;
        check(tag, 32'(cnt), 32'd64);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tw.charIn_i      = 8'h00;
        tw.charValid_i   = 1'b0;
        tw.charAddress_i = 6'd5;
        #1;
        check("pre_reset_cell", 32'(tw.charOutput_o), 32'h20);

        // Reset and power-up clear.
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_ready", 32'(tw.charReady_o), 32'd0);
        wait_clear(1'b0, "reset_clear_len");
        model_clear();
        check("reset_cursor", 32'(tw.cursor_o), 32'd0);
        push_model("reset_buf");
        drain();

        // Basic printing, LF, and same-cycle read of the written cell.
        send(8'h48);
        send(8'h69);
        check("hi_cursor", 32'(tw.cursor_o), 32'd2);
        push_exp(6'd0, 8'h48, "hi_addr0");
        push_exp(6'd1, 8'h69, "hi_addr1");
        drain();
        send(8'h0A);
        check("lf_cursor", 32'(tw.cursor_o), 32'd16);
        tw.charAddress_i = 6'd16;
        tw.charIn_i      = 8'h41;
        tw.charValid_i   = 1'b1;
        #1;
        check("same_cycle_old", 32'(tw.charOutput_o), 32'h20);
        @(posedge clk);
        #1;
        tw.charValid_i = 1'b0;
        model_apply(8'h41);
        check("next_cycle_new", 32'(tw.charOutput_o), 32'h41);
        push_exp(6'd16, 8'h41, "a_addr16");
        push_model("print_buf");
        drain();

        // Form feed with bytes offered throughout the clear.
        send(8'h0C);
        check("ff_ready", 32'(tw.charReady_o), 32'd0);
        check("ff_cursor", 32'(tw.cursor_o), 32'd0);
        wait_clear(1'b1, "ff_clear_len");
        check("ff_cursor_after", 32'(tw.cursor_o), 32'd0);
        push_model("ff_buf");
        drain();

        // Continuous stream of 64 printables wraps the cursor.
        tw.charValid_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tw.charIn_i = 8'(8'h30 + (i % 79));
            @(posedge clk);
            #1;
            model_apply(tw.charIn_i);
        end
        tw.charValid_i = 1'b0;
        check("wrap_cursor", 32'(tw.cursor_o), 32'd0);
        send(8'h70);
        check("wrap_cursor1", 32'(tw.cursor_o), 32'd1);
        push_exp(6'd0, 8'h70, "wrap_overwrite");
        push_model("wrap_buf");
        drain();

        // Backspace, CR, LF wrap, and discarded bytes.
        repeat (4) send(8'h2E);
        check("bs_pre", 32'(tw.cursor_o), 32'd5);
        send(8'h08);
        check("bs_cursor", 32'(tw.cursor_o), 32'd4);
        push_exp(6'd4, 8'h20, "bs_cell");
        drain();
        send(8'h0D);
        check("cr_row0", 32'(tw.cursor_o), 32'd0);
        send(8'h08);
        check("bs_at_zero", 32'(tw.cursor_o), 32'd0);
        send(8'h0A);
        send(8'h0A);
        repeat (3) send(8'h58);
        check("cr_pre", 32'(tw.cursor_o), 32'd35);
        send(8'h0D);
        check("cr_cursor", 32'(tw.cursor_o), 32'd32);
        send(8'h0A);
        repeat (2) send(8'h59);
        check("lf_pre", 32'(tw.cursor_o), 32'd50);
        send(8'h0A);
        check("lf_wrap", 32'(tw.cursor_o), 32'd0);
        send(8'h07);
        send(8'h7F);
        send(8'hFF);
        send(8'h00);
        check("discard_cursor", 32'(tw.cursor_o), 32'd0);
        check("discard_ready", 32'(tw.charReady_o), 32'd1);
        push_model("ctrl_buf");
        drain();

        // Reset during clear restarts the full sweep.
        send(8'h0C);
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        check("midclear_ready", 32'(tw.charReady_o), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_clear(1'b0, "midclear_restart_len");
        model_clear();
        push_model("midclear_buf");
        drain();

        // Reset on the same edge as an accepted byte.
        send(8'h5A);
        send(8'h5A);
        check("coinc_pre", 32'(tw.cursor_o), 32'd2);
        tw.charIn_i    = 8'h41;
        tw.charValid_i = 1'b1;
        reset          = 1'b1;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        tw.charValid_i = 1'b0;
        check("coinc_cursor", 32'(tw.cursor_o), 32'd0);
        tw.charAddress_i = 6'd2;
        #1;
        check("coinc_no_write", 32'(tw.charOutput_o), 32'h20);
        tw.charAddress_i = 6'd0;
        #1;
        check("coinc_uncleared", 32'(tw.charOutput_o), 32'h5A);
        wait_clear(1'b0, "coinc_clear_len");
        model_clear();
        push_model("final_buf");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 SHALL have parameter CLEAR_CHAR, default 8'd32: byte written to every cell on clear and backspace.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port charIn_i, input, 8: character or control byte offered by the producer.
REQ-005 SHALL have port charValid_i, input, 1: charIn_i is valid this cycle.
REQ-006 SHALL have port charReady_o, output, 1: block accepts a byte this cycle.
REQ-007 SHALL have port charAddress_i, input, 6: read address from the text renderer, {row[1:0], col[3:0]}.
REQ-008 SHALL have port charOutput_o, output, 8: buffer byte at charAddress_i.
REQ-009 SHALL have port cursor_o, output, 6: current write position, {row[1:0], col[3:0]}.

Function
REQ-010 SHALL hold a 64-byte text buffer, 4 rows x 16 columns, cell address = row*16 + col.
REQ-011 charOutput_o SHALL be a combinational read of buffer[charAddress_i]; the renderer registers it in the same cycle.
REQ-012 A write SHALL be visible on charOutput_o from the cycle after its accepting edge; a same-cycle read of the written cell returns the old byte.
REQ-013 FSM states SHALL be exactly IDLE and CLEAR; charReady_o = (state == IDLE), decoded from state with no extra register.
REQ-014 A byte SHALL be accepted only on an edge where charValid_i && charReady_o; charIn_i is ignored otherwise.
REQ-015 Accepted 0x20..0x7E: write charIn_i to buffer[cursor]; cursor += 1 modulo 64, so 63 wraps to 0 with no scroll.
REQ-016 Accepted 0x0A (LF): cursor = {row+1 mod 4, 4'd0}; no buffer write.
REQ-017 Accepted 0x0D (CR): column = 0, row unchanged; no buffer write.
REQ-018 Accepted 0x08 (BS), cursor != 0: cursor -= 1 and write CLEAR_CHAR to buffer[cursor-1] on the same edge.
REQ-019 Accepted 0x08 with cursor == 0: no change to cursor or buffer.
REQ-020 Accepted 0x0C (FF): cursor = 0, clear counter = 0, state -> CLEAR.
REQ-021 Any other accepted byte (0x00..0x1F not listed above, 0x7F..0xFF) SHALL be consumed and discarded with no state change.
REQ-022 In CLEAR, each cycle SHALL write CLEAR_CHAR to buffer[clear counter] and then increment the counter.
REQ-023 After the write at counter 63, state SHALL go to IDLE; CLEAR lasts exactly 64 cycles.
REQ-024 While in CLEAR, charValid_i SHALL be ignored, and cursor_o SHALL remain 0.
REQ-025 The read port SHALL stay live in every state; cells not yet cleared return their previous contents.
REQ-026 The block SHALL have at most one buffer write per cycle, and SHALL have no other write sources.

Reset
REQ-027 reset_i high at an edge SHALL set cursor = 0, clear counter = 0 and state = CLEAR, overriding any simultaneous handshake.
REQ-028 After reset, charReady_o SHALL be 0 until 64 edges with reset_i low have completed, then 1.
REQ-029 Reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-030 Buffer contents SHALL be all CLEAR_CHAR after the post-reset clear; initial (pre-reset) contents SHALL be CLEAR_CHAR.

Verification
REQ-031 Reset 1 cycle, release -> charReady_o 0 for 64 cycles then 1; cursor_o 0; all 64 addresses read 0x20.
REQ-032 Send 'H','i' (0x48, 0x69) -> addr 0 = 0x48, addr 1 = 0x69, cursor_o 2; send 0x0A -> cursor_o 16; 0x41 -> addr 16 = 0x41.
REQ-033 Hold charValid_i for 64 printable bytes 0x30+i mod 0x4F -> cursor_o wraps to 0; byte 65 overwrites addr 0.
REQ-034 Cursor 5, send 0x08 -> cursor_o 4, addr 4 = 0x20; at cursor 0 send 0x08 -> no change; cursor 35 send 0x0D -> 32; cursor 50 send 0x0A -> 0.
REQ-035 Fill cells, send 0x0C -> charReady_o low exactly 64 cycles, buffer all 0x20, cursor_o 0; 0x41 and 0x07 offered during CLEAR are not written.
REQ-036 Assert reset_i at clear cycle 30 -> 64 further CLEAR cycles; also reset coincident with an accepted 'A' -> no write, cursor_o 0.
